// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the MEM stage (A, fixed priority)
// and a secondary requester (B), with a starvation counter bounding B's wait.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] a_rdata_q, b_rdata_q;
  logic          a_rvalid_q, b_rvalid_q;
  logic          starve;

  assign starve = (wait_cnt_q == MaxWait);

  // Grants are masked by reset so no access (and no write) slips through while in reset.
  assign b_gnt = reset & b_req & (~a_req | starve);
  assign a_gnt = reset & a_req & ~b_gnt;

  assign mem_addr  = b_gnt ? b_addr  : a_addr;
  assign mem_wdata = b_gnt ? b_wdata : a_wdata;
  assign mem_we    = b_gnt ? b_we    : (a_gnt & a_we);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (b_gnt || !b_req) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != MaxWait) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_q <= 4'd0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      a_rvalid_q <= a_gnt & ~a_we;
      b_rvalid_q <= b_gnt & ~b_we;
      if (a_gnt && !a_we) a_rdata_q <= mem_rdata;
      if (b_gnt && !b_we) b_rdata_q <= mem_rdata;
    end
  end

  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;

endmodule
